// File: rtl/per_xpose_seq_pkg.sv
// per_xpose_seq_pkg: shared types and constants for the transpose-peripheral bus sequencer.
package per_xpose_seq_pkg;
    typedef enum logic [1:0] {WR, RD_REQ, RD_CAP, RD_OUT} state_t;
    localparam int AW = 14;
    localparam int DW = 16;
    localparam logic [1:0] PER_WE_WORD = 2'b11;
    localparam logic [1:0] PER_WE_READ = 2'b00;
    localparam logic [AW-1:0] BASE_ADDR_DEF = 14'h88;
endpackage

// File: rtl/per_xpose_seq_if.sv
// per_xpose_seq_if: input stream, output stream and peripheral bus of the sequencer.
interface per_xpose_seq_if;
    import per_xpose_seq_pkg::*;
    logic s_valid;
    logic s_ready;
    logic [DW-1:0] s_data;
    logic m_valid;
    logic m_ready;
    logic [DW-1:0] m_data;
    logic [AW-1:0] per_addr;
    logic [DW-1:0] per_din;
    logic per_en;
    logic [1:0] per_we;
    logic [DW-1:0] per_dout;
    modport master (
        input s_valid, s_data, m_ready, per_dout,
        output s_ready, m_valid, m_data, per_addr, per_din, per_en, per_we
    );
    modport slave (
        output s_valid, s_data, m_ready, per_dout,
        input s_ready, m_valid, m_data, per_addr, per_din, per_en, per_we
    );
endinterface

// File: rtl/per_xpose_seq.sv
// per_xpose_seq: writes NWORDS stream words to the peripheral, then reads them back as a stream.
// Define PER_XPOSE_SEQ_STATS_EN to add the saturating blk_cnt completed-block counter.
module per_xpose_seq
    import per_xpose_seq_pkg::*;
#(
    parameter logic [AW-1:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int NWORDS = 4
) (
    input logic mclk,
    input logic puc_rst_n,
    per_xpose_seq_if.master bus,
    output logic busy,
    output logic done
`ifdef PER_XPOSE_SEQ_STATS_EN
    ,
    output logic [15:0] blk_cnt
`endif
);
    localparam int IW = $clog2(NWORDS);
    localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

    if (NWORDS < 2 || NWORDS > 16 || int'(BASE_ADDR) + NWORDS - 1 > (1 << AW) - 1) begin : g_bad_cfg
        $error("per_xpose_seq: NWORDS out of range or address window wraps");
    end

    state_t state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic wr_hs, out_hs, last, launch;

    always_comb begin
        state_nxt = state;
        idx_nxt = idx;
        last = idx == LAST;
        wr_hs = state == WR && bus.s_valid;
        out_hs = state == RD_OUT && bus.m_ready;
        launch = wr_hs || state == RD_REQ;
        case (state)
            WR: if (bus.s_valid) begin
                idx_nxt = last ? '0 : idx + 1'b1;
                state_nxt = last ? RD_REQ : WR;
            end
            RD_REQ: state_nxt = RD_CAP;
            RD_CAP: state_nxt = RD_OUT;
            RD_OUT: if (bus.m_ready) begin
                idx_nxt = last ? '0 : idx + 1'b1;
                state_nxt = last ? WR : RD_REQ;
            end
            default: state_nxt = WR;
        endcase
    end

    // bus outputs are registered and fall back to zero whenever no access is launched
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state <= WR;
            idx <= '0;
            bus.per_en <= 1'b0;
            bus.per_we <= PER_WE_READ;
            bus.per_addr <= '0;
            bus.per_din <= '0;
            bus.m_valid <= 1'b0;
            bus.m_data <= '0;
            done <= 1'b0;
        end else begin
            state <= state_nxt;
            idx <= idx_nxt;
            bus.per_en <= launch;
            bus.per_we <= wr_hs ? PER_WE_WORD : PER_WE_READ;
            bus.per_addr <= launch ? BASE_ADDR + AW'(idx) : '0;
            bus.per_din <= wr_hs ? bus.s_data : '0;
            bus.m_valid <= state == RD_CAP || (bus.m_valid && !out_hs);
            bus.m_data <= state == RD_CAP ? bus.per_dout : bus.m_data;
            done <= out_hs && last;
        end
    end

    assign bus.s_ready = state == WR;
    assign busy = !(state == WR && idx == '0);

`ifdef PER_XPOSE_SEQ_STATS_EN
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) blk_cnt <= '0;
        else if (out_hs && last && blk_cnt != 16'hFFFF) blk_cnt <= blk_cnt + 16'd1;
    end
`endif
endmodule
